// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into
// 32-bit words, writes them from address 0 upward and holds the core meanwhile.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for start; core released
  // RECV  | accepting bytes of the current word
  // WRITE | im_we cycle for the assembled word
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] len_r;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] word_cnt_inc;
  logic [1:0]          byte_cnt;
  // Only three bytes need holding; the fourth goes straight into im_wdata.
  logic [23:0]         shift_r;

  logic xfer, word_last, len_zero, len_bad, last_word;

  assign xfer         = (state == RECV) && byte_valid;
  assign word_last    = xfer && (byte_cnt == 2'd3);
  assign len_zero     = (len == '0);
  assign len_bad      = (len > MAX_LEN);
  assign word_cnt_inc = word_cnt + 1'b1;
  assign last_word    = (word_cnt_inc == len_r);

  assign byte_ready = (state == RECV);
  assign busy       = (state != IDLE);
  assign cpu_hold   = busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_zero)     state_nxt = DONE;
          else if (!len_bad) state_nxt = RECV;
        end
      end
      RECV:    if (word_last) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : RECV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      shift_r  <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_zero) begin
              done <= 1'b1;
            end else if (len_bad) begin
              err <= 1'b1;
            end else begin
              len_r    <= len;
              word_cnt <= '0;
              byte_cnt <= '0;
            end
          end
        end
        RECV: begin
          if (xfer) begin
            shift_r  <= {shift_r[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_wdata <= {shift_r, byte_data};
              im_addr  <= word_cnt[ADDR_WIDTH-1:0];
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt_inc;
          if (last_word) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-decision vector table, cycle-exact
// sequences and a write scoreboard fed by the byte driver.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, im_we, cpu_hold, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  int            writes = 0;
  logic [AW-1:0] last_addr = '0;
  bit            hold_watch = 0;
  int            hold_drops = 0;
  logic [AW-1:0] addr_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (hold_watch && !cpu_hold) hold_drops++;
      if (im_we) begin
        wr_t e;
        writes++;
        last_addr = im_addr;
        check("ready_in_write", byte_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_qsize", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", im_addr, e.addr);
          check("wr_data", im_wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("reset_outputs",
          {byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err}, 0);
    exp_q.delete();
    hold_watch = 0;
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic start_load(input logic [AW:0] l);
    start = 1'b1;
    len = l;
    addr_exp = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    bit ok;
    bit rdy;
    ok = 0;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_data = d;
    for (int i = 0; i < 40; i++) begin
      rdy = byte_ready;
      tick();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    check("byte_accepted", ok, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    wr_t e;
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], gap);
    e.addr = addr_exp;
    e.data = w;
    exp_q.push_back(e);
    addr_exp++;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    byte_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("done_seen", seen, 1);
  endtask

  typedef struct {
    logic [AW:0] len;
    logic        exp_err;
    logic        exp_done;
    logic        exp_busy;
    logic        exp_ready;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   wb;
    wr_t  e;

    vecs[0] = '{9'd0,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{9'd257, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{9'd300, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{9'd511, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{9'd1,   1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{9'd256, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{9'd255, 1'b0, 1'b0, 1'b1, 1'b1};

    #1;
    do_reset();

    // Start decision in IDLE, observed in cycle 1.
    for (int i = 0; i < 7; i++) begin
      start_load(vecs[i].len);
      check($sformatf("vec%0d_err", i),   err,        vecs[i].exp_err);
      check($sformatf("vec%0d_done", i),  done,       vecs[i].exp_done);
      check($sformatf("vec%0d_busy", i),  busy,       vecs[i].exp_busy);
      check($sformatf("vec%0d_ready", i), byte_ready, vecs[i].exp_ready);
      do_reset();
    end

    // Single word, cycle exact.
    wb = writes;
    start_load(9'd1);
    check("c1_busy", busy, 1);
    check("c1_ready", byte_ready, 1);
    byte_valid = 1'b1; byte_data = 8'h20; tick();
    byte_data = 8'h08; tick();
    byte_data = 8'h00; tick();
    byte_data = 8'h05;
    e.addr = '0; e.data = 32'h2008_0005; exp_q.push_back(e);
    tick();
    byte_valid = 1'b0;
    check("c5_we", im_we, 1);
    check("c5_addr", im_addr, 0);
    check("c5_wdata", im_wdata, 32'h2008_0005);
    check("c5_ready", byte_ready, 0);
    check("c5_done", done, 0);
    tick();
    check("c6_done", done, 1);
    check("c6_we", im_we, 0);
    check("c6_hold", cpu_hold, 1);
    tick();
    check("c7_hold", cpu_hold, 0);
    check("c7_busy", busy, 0);
    check("c7_done", done, 0);
    check("c7_wdata_held", im_wdata, 32'h2008_0005);
    check("single_writes", writes - wb, 1);

    // len=0: done in cycle 1, no write, no err.
    wb = writes;
    start_load(9'd0);
    check("len0_done", done, 1);
    check("len0_err", err, 0);
    check("len0_we", im_we, 0);
    tick();
    check("len0_done_pulse", done, 0);
    check("len0_busy_after", busy, 0);
    check("len0_writes", writes - wb, 0);

    // len=257: err one cycle, stays IDLE.
    start_load(9'd257);
    check("len257_err", err, 1);
    check("len257_busy", busy, 0);
    tick();
    check("len257_err_pulse", err, 0);
    check("len257_busy_after", busy, 0);

    // Stalled stream, len=3.
    wb = writes;
    start_load(9'd3);
    for (int w = 0; w < 3; w++) send_word($urandom(), 1);
    wait_done();
    check("stall_writes", writes - wb, 3);
    check("stall_last_addr", last_addr, 2);

    // Start during a running load is ignored.
    tick();
    wb = writes;
    start_load(9'd2);
    start = 1'b1; len = 9'd5; tick();
    start = 1'b0; len = '0;
    send_word($urandom(), 0);
    send_word($urandom(), 0);
    wait_done();
    repeat (10) tick();
    check("ignore_start_writes", writes - wb, 2);
    check("ignore_start_busy", busy, 0);

    // Reset after word 0 plus two bytes of word 1.
    wb = writes;
    start_load(9'd2);
    send_word(32'hDEAD_BEEF, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset();
    repeat (8) tick();
    check("midreset_writes", writes - wb, 1);
    start_load(9'd1);
    send_word(32'hCAFE_0001, 1);
    wait_done();
    tick();
    check("reload_writes", writes - wb, 2);
    check("reload_addr", last_addr, 0);

    // len=256: last write at 255.
    wb = writes;
    start_load(9'd256);
    hold_drops = 0;
    hold_watch = 1;
    for (int w = 0; w < 256; w++) send_word($urandom(), 0);
    wait_done();
    hold_watch = 0;
    check("len256_writes", writes - wb, 256);
    check("len256_last_addr", last_addr, 255);
    check("len256_hold", hold_drops, 0);
    tick();

    // 100 random words with random valid gaps.
    wb = writes;
    start_load(9'd100);
    hold_drops = 0;
    hold_watch = 1;
    for (int w = 0; w < 100; w++) send_word($urandom(), 1);
    wait_done();
    hold_watch = 0;
    check("rand_writes", writes - wb, 100);
    check("rand_last_addr", last_addr, 99);
    check("rand_hold", hold_drops, 0);
    tick();
    check("rand_busy_after", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
